// File: rtl/uart_rx_mini.sv
// uart_rx_mini: oversampling 8N1 UART receiver with an RX FIFO, sticky error flags and an APB slave port.
// Optional feature macro: UART_RX_RTS_EN enables the registered rts flow-control output.
module uart_rx_mini #(
    parameter int BIT_CYCLES = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    input  logic        rx,
    output logic        rts,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CC_W  = $clog2(BIT_CYCLES);
    localparam logic [CC_W-1:0]  CC_LAST   = CC_W'(BIT_CYCLES - 1);
    localparam logic [CC_W-1:0]  CC_HALF   = CC_W'(BIT_CYCLES / 2 - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t            state_q, state_d;
    logic [CC_W-1:0]   cc_q, cc_d;
    logic [2:0]        bc_q, bc_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              irq_q, irq_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              push;
    logic              ferr_set;
    logic              rd_access;
    logic              wr_access;
    logic              sel_data;
    logic              sel_status;
    logic              empty;
    logic              full;
    logic              pop;
    logic              accept;
    logic              ovr_set;
    logic [31:0]       count_wide;
    logic [3:0]        fill;
    logic              unused_bits;

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign irq          = irq_q;

    // Address and data bits outside the decoded fields are intentionally ignored.
    assign unused_bits = ^{apbs_paddr[15:4], apbs_paddr[1:0],
                           apbs_pwdata[31:4], apbs_pwdata[1:0]};

    assign rd_access  = apbs_psel & apbs_penable & ~apbs_pwrite;
    assign wr_access  = apbs_psel & apbs_penable & apbs_pwrite;
    assign sel_data   = (apbs_paddr[3:2] == 2'b00);
    assign sel_status = (apbs_paddr[3:2] == 2'b01);

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_CNT);
    assign pop        = rd_access & sel_data & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept     = push & (~full | pop);
    assign ovr_set    = push & full & ~pop;

    assign count_wide = 32'(count_q);
    assign fill       = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        cc_d      = cc_q + CC_W'(1);
        bc_d      = bc_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cc_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cc_q == CC_HALF) begin
                    cc_d    = '0;
                    bc_d    = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cc_q == CC_LAST) begin
                    cc_d    = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bc_d    = bc_q + 3'd1;
                    if (bc_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cc_q == CC_LAST) begin
                    cc_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cc_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and sticky flags; a flag set in the same cycle as its clear wins.
    always_comb begin
        wptr_d      = wptr_q + {{(PTR_W-1){1'b0}}, accept};
        rptr_d      = rptr_q + {{(PTR_W-1){1'b0}}, pop};
        count_d     = count_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
        overrun_d   = ovr_set |
                      (overrun_q & ~(wr_access & sel_status & apbs_pwdata[2]));
        frame_err_d = ferr_set |
                      (frame_err_q & ~(wr_access & sel_status & apbs_pwdata[3]));
        irq_d       = ~empty | overrun_q | frame_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cc_q        <= cc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_comb begin
        apbs_prdata = '0;
        case (apbs_paddr[3:2])
            2'b00: begin
                if (!empty) begin
                    apbs_prdata = {24'h0, mem_q[rptr_q]};
                end
            end
            2'b01: begin
                apbs_prdata = {24'h0, fill, frame_err_q, overrun_q, full, ~empty};
            end
            default: begin
                apbs_prdata = '0;
            end
        endcase
    end

`ifdef UART_RX_RTS_EN
    logic rts_q, rts_d;

    assign rts_d = (count_q >= (PTR_W + 1)'(FIFO_DEPTH - 2));
    assign rts   = rts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= rts_d;
        end
    end
`else
    assign rts = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_mini.sv
// Testbench for uart_rx_mini: table vectors, directed multi-cycle corner cases and random frames
// checked against a queue-based reference model of the receiver and its register file.
module tb_uart_rx_mini;

    localparam int BIT_CYCLES = 16;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_RX_RTS_EN
    localparam bit RTS_EN = 1'b1;
`else
    localparam bit RTS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        apbs_psel = 1'b0;
    logic        apbs_penable = 1'b0;
    logic        apbs_pwrite = 1'b0;
    logic [15:0] apbs_paddr = 16'h0;
    logic [31:0] apbs_pwdata = 32'h0;
    logic [31:0] apbs_prdata;
    logic        apbs_pready;
    logic        apbs_pslverr;
    logic        rx = 1'b1;
    logic        rts;
    logic        irq;

    always #5 clk = ~clk;

    uart_rx_mini #(
        .BIT_CYCLES(BIT_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .apbs_psel   (apbs_psel),
        .apbs_penable(apbs_penable),
        .apbs_pwrite (apbs_pwrite),
        .apbs_paddr  (apbs_paddr),
        .apbs_pwdata (apbs_pwdata),
        .apbs_prdata (apbs_prdata),
        .apbs_pready (apbs_pready),
        .apbs_pslverr(apbs_pslverr),
        .rx          (rx),
        .rts         (rts),
        .irq         (irq)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stop_ok;
        logic        clear_after;
        logic [31:0] exp_status;
        logic [31:0] exp_data;
    } vec_t;

    int         assertions = 0;
    int         failures = 0;
    logic [7:0] model_q[$];
    logic       model_ovr = 1'b0;
    logic       model_ferr = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: a byte queue plus two sticky flags.
    function automatic logic [31:0] model_status();
        int         n;
        logic [3:0] f;
        n = model_q.size();
        f = (n > 15) ? 4'hF : 4'(n);
        return {24'h0, f, model_ferr, model_ovr, (n == FIFO_DEPTH), (n != 0)};
    endfunction

    function automatic logic [31:0] model_pop();
        logic [7:0] b;
        if (model_q.size() == 0) return 32'h0;
        b = model_q.pop_front();
        return {24'h0, b};
    endfunction

    function automatic void model_frame(input logic [7:0] data, input logic stop_ok);
        if (!stop_ok) model_ferr = 1'b1;
        else if (model_q.size() < FIFO_DEPTH) model_q.push_back(data);
        else model_ovr = 1'b1;
    endfunction

    task automatic apb_read(input logic [15:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        apbs_psel = 1'b1; apbs_penable = 1'b0; apbs_pwrite = 1'b0; apbs_paddr = addr;
        @(posedge clk); #1;
        apbs_penable = 1'b1;
        #2 data = apbs_prdata;
        @(posedge clk); #1;
        apbs_psel = 1'b0; apbs_penable = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        apbs_psel = 1'b1; apbs_penable = 1'b0; apbs_pwrite = 1'b1;
        apbs_paddr = addr; apbs_pwdata = data;
        @(posedge clk); #1;
        apbs_penable = 1'b1;
        @(posedge clk); #1;
        apbs_psel = 1'b0; apbs_penable = 1'b0; apbs_pwrite = 1'b0;
    endtask

    // One 8N1 character; the line stays low for hold extra cycles after a low stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int hold);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10 * BIT_CYCLES; i++) begin
            @(posedge clk); #1;
            rx = bits[i / BIT_CYCLES];
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        rx = 1'b1;
    endtask

    task automatic frame(input logic [7:0] data, input logic stop_ok, input int hold);
        send_frame(data, stop_ok, hold);
        model_frame(data, stop_ok);
    endtask

    task automatic read_status(input string name, input logic [31:0] expected);
        logic [31:0] rd;
        apb_read(16'h0004, rd);
        checkOutput(name, rd, expected);
    endtask

    task automatic read_data(input string name, input logic [31:0] expected);
        logic [31:0] rd;
        logic [31:0] unused_model;
        apb_read(16'h0000, rd);
        unused_model = model_pop();
        checkOutput(name, rd, expected);
    endtask

    task automatic write_status(input logic [31:0] w);
        apb_write(16'h0004, w);
        if (w[2]) model_ovr = 1'b0;
        if (w[3]) model_ferr = 1'b0;
    endtask

    task automatic check_rts(input string name);
        logic exp_rts;
        exp_rts = RTS_EN && (model_q.size() >= FIFO_DEPTH - 2);
        checkOutput(name, {31'h0, rts}, {31'h0, exp_rts});
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        frame(v.data, v.stop_ok, 0);
        read_status($sformatf("vec%0d_status", idx), v.exp_status);
        read_data($sformatf("vec%0d_data", idx), v.exp_data);
        if (v.clear_after) write_status(32'h0000_000C);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] rd;
        logic [9:0]  bits;
        logic [7:0]  rbyte;
        logic        rok;
        int          nrd;
        int          hold;
        logic [31:0] w;

        vecs[0] = '{8'h3C, 1'b1, 1'b0, 32'h11, 32'h3C};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 32'h11, 32'hFF};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 32'h11, 32'h00};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 32'h08, 32'h00};
        vecs[4] = '{8'h55, 1'b1, 1'b1, 32'h19, 32'h55};
        vecs[5] = '{8'hAA, 1'b1, 1'b0, 32'h11, 32'hAA};

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        apbs_paddr = 16'h0000;
        #1 checkOutput("rst_prdata_data", apbs_prdata, 32'h0);
        apbs_paddr = 16'h0004;
        #1 checkOutput("rst_prdata_status", apbs_prdata, 32'h0);
        checkOutput("rst_pready", {31'h0, apbs_pready}, 32'h1);
        checkOutput("rst_pslverr", {31'h0, apbs_pslverr}, 32'h0);
        checkOutput("rst_rts", {31'h0, rts}, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] single byte 0xA5");
        frame(8'hA5, 1'b1, 0);
        #1 checkOutput("a5_irq_set", {31'h0, irq}, 32'h1);
        read_status("a5_status", 32'h11);
        apb_read(16'h0008, rd);
        checkOutput("unmapped_8", rd, 32'h0);
        apb_write(16'h000C, 32'hFFFF_FFFF);
        apb_read(16'h000C, rd);
        checkOutput("unmapped_c", rd, 32'h0);
        read_status("a5_status_after_unmapped", 32'h11);
        read_data("a5_data", 32'hA5);
        checkOutput("a5_irq_lag", {31'h0, irq}, 32'h1);
        @(posedge clk); #1;
        checkOutput("a5_irq_drop", {31'h0, irq}, 32'h0);
        read_status("a5_status_empty", 32'h00);
        read_data("empty_read", 32'h00);
        checkOutput("pready_const", {31'h0, apbs_pready}, 32'h1);
        checkOutput("pslverr_const", {31'h0, apbs_pslverr}, 32'h0);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        $display("[TB] overrun");
        for (int i = 1; i <= 9; i++) frame(8'(i), 1'b1, 0);
        read_status("ovr_status_full", 32'h87);
        for (int i = 1; i <= 8; i++) read_data($sformatf("ovr_data%0d", i), 32'(i));
        read_status("ovr_status_drained", 32'h04);
        write_status(32'h0);
        read_status("ovr_write0_keeps", 32'h04);
        write_status(32'h4);
        read_status("ovr_cleared", 32'h00);

        $display("[TB] frame error with held break");
        frame(8'hC3, 1'b0, 40);
        read_status("brk_status", 32'h08);
        #1 checkOutput("brk_irq", {31'h0, irq}, 32'h1);
        frame(8'h3C, 1'b1, 0);
        read_status("brk_next_status", 32'h19);
        read_data("brk_next_data", 32'h3C);
        write_status(32'h8);
        read_status("brk_cleared", 32'h00);

        $display("[TB] short glitch");
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        read_status("glitch_status", 32'h00);
        #1 checkOutput("glitch_irq", {31'h0, irq}, 32'h0);
        frame(8'h5E, 1'b1, 0);
        read_data("glitch_next_data", 32'h5E);

        $display("[TB] pop and push in the same cycle");
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b1, 0);
        read_status("same_cycle_full", 32'h83);
        fork
            send_frame(8'h77, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (153) @(posedge clk);
                #1;
                apbs_psel = 1'b1; apbs_penable = 1'b0; apbs_pwrite = 1'b0; apbs_paddr = 16'h0;
                @(posedge clk); #1;
                apbs_penable = 1'b1;
                #2 rd = apbs_prdata;
                @(posedge clk); #1;
                apbs_psel = 1'b0; apbs_penable = 1'b0;
            end
        join
        w = model_pop();
        model_frame(8'h77, 1'b1);
        checkOutput("same_cycle_pop", rd, 32'h10);
        read_status("same_cycle_status", 32'h83);
        for (int i = 1; i < 8; i++) read_data($sformatf("same_cycle_data%0d", i), 32'h10 + 32'(i));
        read_data("same_cycle_last", 32'h77);

        $display("[TB] reset mid-frame");
        frame(8'h11, 1'b1, 0);
        frame(8'h22, 1'b0, 0);
        #1 checkOutput("pre_reset_irq", {31'h0, irq}, 32'h1);
        bits = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i <= 5 * BIT_CYCLES + 8; i++) begin
            @(posedge clk); #1;
            rx = bits[i / BIT_CYCLES];
        end
        rst_n = 1'b0;
        apbs_paddr = 16'h0004;
        #1 checkOutput("mid_rst_status", apbs_prdata, 32'h0);
        apbs_paddr = 16'h0000;
        #1 checkOutput("mid_rst_data", apbs_prdata, 32'h0);
        checkOutput("mid_rst_irq", {31'h0, irq}, 32'h0);
        checkOutput("mid_rst_rts", {31'h0, rts}, 32'h0);
        checkOutput("mid_rst_pready", {31'h0, apbs_pready}, 32'h1);
        rx = 1'b1;
        model_q.delete();
        model_ovr = 1'b0;
        model_ferr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        frame(8'h5A, 1'b1, 0);
        read_status("post_rst_status", 32'h11);
        read_data("post_rst_data", 32'h5A);

        $display("[TB] flow control");
        for (int i = 0; i < 5; i++) frame(8'hB0 + 8'(i), 1'b1, 0);
        repeat (2) @(posedge clk);
        #1 check_rts("rts_count5");
        frame(8'hB5, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1 check_rts("rts_count6");
        read_data("rts_pop", 32'hB0);
        repeat (2) @(posedge clk);
        #1 check_rts("rts_after_pop");
        for (int i = 1; i < 6; i++) read_data($sformatf("rts_drain%0d", i), 32'hB0 + 32'(i));

        $display("[TB] random frames");
        for (int it = 0; it < 24; it++) begin
            rbyte = 8'($urandom);
            rok = ($urandom_range(0, 9) != 0);
            hold = rok ? 0 : int'($urandom_range(0, 30));
            nrd = int'($urandom_range(0, 2));
            frame(rbyte, rok, hold);
            read_status($sformatf("rand%0d_status", it), model_status());
            for (int r = 0; r < nrd; r++) begin
                apb_read(16'h0000, rd);
                checkOutput($sformatf("rand%0d_data%0d", it, r), rd, model_pop());
            end
            if ($urandom_range(0, 3) == 0) begin
                w = 32'($urandom_range(0, 15));
                write_status(w);
            end
            repeat (2) @(posedge clk);
            #1 checkOutput($sformatf("rand%0d_irq", it), {31'h0, irq},
                           {31'h0, (model_q.size() != 0) | model_ovr | model_ferr});
            check_rts($sformatf("rand%0d_rts", it));
        end
        read_status("rand_final_status", model_status());

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
